// File: rtl/scan_tap_chan.sv
// Addressable scan tap: forwards tck/tms one clk late, and either bypasses tdi or
// swaps a captured outbound word for a new inbound word when addressed.
module scan_tap_chan #(
  parameter int                    NUM_IOS    = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDRESS    = ADDR_WIDTH'(1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_tck,
  input  logic               i_tms,
  input  logic               i_tdi,
  input  logic [NUM_IOS-1:0] outbound,
  output logic [NUM_IOS-1:0] inbound,
  output logic               o_tck,
  output logic               o_tms,
  output logic               o_tdo,
  output logic               selected
);

  localparam int MAX_W = (ADDR_WIDTH > NUM_IOS) ? ADDR_WIDTH : NUM_IOS;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(NUM_IOS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_UPDATE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_sr_q, addr_sr_d;
  logic [NUM_IOS-1:0]      data_sr_q, data_sr_d;
  logic [NUM_IOS-1:0]      inbound_q, inbound_d;
  logic                    tck_q;
  logic                    o_tck_q, o_tms_q, o_tdo_q, o_tdo_d;
  logic                    selected_q, selected_d;

  logic                    rise;
  logic                    frame_start;
  logic [CNT_W-1:0]        cnt_inc;
  logic [ADDR_WIDTH-1:0]   addr_shift;
  logic [NUM_IOS-1:0]      data_shift;

  always_comb begin
    rise        = i_tck & ~tck_q;
    // A rise during UPDATE is treated exactly like one in IDLE so no edge is lost.
    frame_start = rise & i_tms & ((state_q == S_IDLE) | (state_q == S_UPDATE));
    cnt_inc     = cnt_q + CNT_W'(1);
    addr_shift  = (addr_sr_q << 1) | ADDR_WIDTH'(i_tdi);
    data_shift  = (data_sr_q << 1) | NUM_IOS'(i_tdi);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_sr_q  <= '0;
      data_sr_q  <= '0;
      inbound_q  <= '0;
      tck_q      <= 1'b0;
      o_tck_q    <= 1'b0;
      o_tms_q    <= 1'b0;
      o_tdo_q    <= 1'b0;
      selected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_sr_q  <= addr_sr_d;
      data_sr_q  <= data_sr_d;
      inbound_q  <= inbound_d;
      tck_q      <= i_tck;
      o_tck_q    <= i_tck;
      o_tms_q    <= i_tms;
      o_tdo_q    <= o_tdo_d;
      selected_q <= selected_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (rise) begin
          if (!i_tms)                   state_d = S_IDLE;
          else if (cnt_inc == CNT_ADDR) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rise && !i_tms) state_d = (cnt_q == CNT_DATA) ? S_UPDATE : S_IDLE;
      end
      S_UPDATE: begin
        state_d = frame_start ? S_ADDR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    addr_sr_d  = addr_sr_q;
    data_sr_d  = data_sr_q;
    inbound_d  = inbound_q;
    selected_d = selected_q;

    if (state_q == S_UPDATE && selected_q) inbound_d = data_sr_q;

    if (frame_start) begin
      cnt_d      = '0;
      selected_d = 1'b0;
      data_sr_d  = outbound;
    end

    if (state_q == S_ADDR && rise && i_tms) begin
      addr_sr_d = addr_shift;
      if (cnt_inc == CNT_ADDR) begin
        cnt_d      = '0;
        selected_d = (addr_shift == ADDRESS);
      end else begin
        cnt_d = cnt_inc;
      end
    end

    // Bits beyond the data-frame length are dropped; the counter saturates.
    if (state_q == S_DATA && rise && i_tms && cnt_q < CNT_DATA) begin
      data_sr_d = data_shift;
      cnt_d     = cnt_inc;
    end

    o_tdo_d = (state_q == S_DATA && selected_q) ? data_sr_q[NUM_IOS-1] : i_tdi;
  end

  assign inbound  = inbound_q;
  assign o_tck    = o_tck_q;
  assign o_tms    = o_tms_q;
  assign o_tdo    = o_tdo_q;
  assign selected = selected_q;

endmodule

// File: tb/tb_scan_tap_chan.sv
// Directed bench for scan_tap_chan with address 0x03, 8-bit frames, tck period 4 clk.
module tb_scan_tap_chan;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_tck, i_tms, i_tdi;
  logic [7:0] outbound;
  logic [7:0] inbound;
  logic       o_tck, o_tms, o_tdo, selected;

  int n_cmp = 0;
  int n_err = 0;

  logic       last_tdo, last_otck, last_otms;
  logic [7:0] last_inb1, last_inb2;
  logic       tdo_log [16];
  logic [7:0] exp_tdo;

  scan_tap_chan #(.NUM_IOS(8), .ADDR_WIDTH(8), .ADDRESS(8'h03)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_tck    (i_tck),
    .i_tms    (i_tms),
    .i_tdi    (i_tdi),
    .outbound (outbound),
    .inbound  (inbound),
    .o_tck    (o_tck),
    .o_tms    (o_tms),
    .o_tdo    (o_tdo),
    .selected (selected)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One scan bit: tck high 2 clk, low 2 clk; outputs sampled 1 and 2 clk after the rise.
  task automatic scan_bit(input logic tms, input logic tdi);
    i_tms = tms;
    i_tdi = tdi;
    i_tck = 1'b1;
    @(posedge clk); #1;
    last_tdo  = o_tdo;
    last_otck = o_tck;
    last_otms = o_tms;
    last_inb1 = inbound;
    @(posedge clk); #1;
    last_inb2 = inbound;
    i_tck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [15:0] data,
                            input int nbits, input bit chk_byp);
    scan_bit(1'b1, 1'b0);
    if (chk_byp) check("bypass_start", {31'd0, last_tdo}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      scan_bit(1'b1, addr[7-i]);
      if (chk_byp) check("bypass_addr", {31'd0, last_tdo}, {31'd0, addr[7-i]});
    end
    for (int i = 0; i < nbits; i++) begin
      scan_bit(1'b1, data[nbits-1-i]);
      tdo_log[i] = last_tdo;
      if (chk_byp) check("bypass_data", {31'd0, last_tdo}, {31'd0, data[nbits-1-i]});
    end
  endtask

  initial begin
    reset = 1'b1;
    i_tck = 1'($urandom); i_tms = 1'($urandom); i_tdi = 1'($urandom);
    outbound = 8'($urandom);
    @(posedge clk); #1;
    i_tck = 1'($urandom); i_tms = 1'($urandom); i_tdi = 1'($urandom);
    @(posedge clk); #1;
    check("rst_inbound",  {24'd0, inbound}, 32'h00);
    check("rst_o_tck",    {31'd0, o_tck},   32'd0);
    check("rst_o_tms",    {31'd0, o_tms},   32'd0);
    check("rst_o_tdo",    {31'd0, o_tdo},   32'd0);
    check("rst_selected", {31'd0, selected}, 32'd0);
    reset = 1'b0; i_tck = 1'b0; i_tms = 1'b0; i_tdi = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Matching frame: capture 0x3C out, write 0xA5 in.
    outbound = 8'h3C;
    send_frame(8'h03, 16'h00A5, 8, 1'b0);
    check("f1_o_tck", {31'd0, last_otck}, 32'd1);
    check("f1_o_tms", {31'd0, last_otms}, 32'd1);
    check("f1_selected", {31'd0, selected}, 32'd1);
    exp_tdo = 8'b0011_1100;
    for (int i = 0; i < 8; i++) check("f1_tdo", {31'd0, tdo_log[i]}, {31'd0, exp_tdo[7-i]});
    scan_bit(1'b0, 1'b0);
    check("f1_inbound_1clk", {24'd0, last_inb1}, 32'h00);
    check("f1_inbound_2clk", {24'd0, last_inb2}, 32'hA5);

    // Non-matching frame: pure bypass, no update.
    send_frame(8'h04, 16'h00FF, 8, 1'b1);
    check("f2_selected", {31'd0, selected}, 32'd0);
    scan_bit(1'b0, 1'b1);
    check("f2_bypass_end", {31'd0, last_tdo}, 32'd1);
    check("f2_inbound", {24'd0, last_inb2}, 32'hA5);

    // Abort after 5 data bits.
    send_frame(8'h03, 16'h001F, 5, 1'b0);
    scan_bit(1'b0, 1'b1);
    check("abort_inbound", {24'd0, last_inb2}, 32'hA5);
    scan_bit(1'b0, 1'b0);
    check("abort_idle_bypass", {31'd0, last_tdo}, 32'd0);

    // Over-long frame: last 2 of 10 bits ignored.
    send_frame(8'h03, 16'h02AB, 10, 1'b0);
    scan_bit(1'b0, 1'b0);
    check("long_inbound", {24'd0, last_inb2}, 32'hAA);

    // Reset on the 3rd data bit, then a clean frame.
    send_frame(8'h03, 16'h0001, 2, 1'b0);
    i_tms = 1'b1; i_tdi = 1'b0; i_tck = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; i_tck = 1'b0; i_tms = 1'b0;
    check("midrst_inbound",  {24'd0, inbound}, 32'h00);
    check("midrst_selected", {31'd0, selected}, 32'd0);
    check("midrst_o_tdo",    {31'd0, o_tdo},   32'd0);
    repeat (2) @(posedge clk);
    #1;
    send_frame(8'h03, 16'h005A, 8, 1'b0);
    scan_bit(1'b0, 1'b0);
    check("post_rst_inbound", {24'd0, last_inb2}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
